bcd2bin_seq: RTL and testbench
==============================

Name: bcd2bin_seq

Overview:
- Sequential packed-BCD to binary converter using reverse double dabble: shift right one bit per clock, then subtract 3 from every BCD digit that is >= 8.
- Converts operator/display-side decimal values (4 digits, 0..9999) back into binary for the arithmetic datapath.
- Valid/ready handshake on both sides; flags non-decimal digits instead of converting them.

Parameters:
- DIGITS, 4, number of packed BCD digits at the input.
- BIN_W, 14, binary result width; must satisfy 2^BIN_W > 10^DIGITS - 1 (14 covers 9999).

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  bcd_in is valid.
- in_ready  out  1  converter can accept a value (high only in IDLE).
- bcd_in  in  4*DIGITS  packed BCD, digit 0 in [3:0].
- out_valid  out  1  bin_out and err are valid.
- out_ready  in  1  consumer accepts the result.
- bin_out  out  BIN_W  binary result.
- err  out  1  at least one input digit was > 9.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0, shift register=0.
  - in_ready=1 after release; out_valid=0, bin_out=0, err=0.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready, if every digit <= 9: load shift register {bcd_in, BIN_W'b0} (width 4*DIGITS+BIN_W), clear counter, go to CONV.
  - If any digit > 9: skip conversion, set err=1, bin_out=0, go to DONE.
- CONV:
  - in_ready=0. Each edge performs one iteration: logical shift right by 1, then each digit field that is >= 8 has 3 subtracted.
  - Counter increments. After iteration BIN_W (counter == BIN_W-1 at that edge), capture the low BIN_W bits into bin_out, set err=0, go to DONE.
- DONE:
  - out_valid=1; bin_out and err held stable.
  - On out_ready=1, go to IDLE and clear out_valid on that edge.
  - out_ready=0 holds the result indefinitely.
- Latency:
  - Valid input: accept edge, then BIN_W iteration edges; out_valid is visible after edge BIN_W+1 counted from the accept edge inclusive (15 edges with defaults).
  - Invalid input: out_valid is visible after the accept edge (1 edge).
- Throughput: no overlap. Minimum period per valid conversion is BIN_W+2 cycles (accept, BIN_W iterations, DONE with out_ready=1).
- in_valid while not in IDLE: ignored, not latched. The producer must hold in_valid until in_ready.
- Boundaries:
  - 0000 produces 0.
  - 9999 produces 9999; no overflow is possible for legal input.
  - The BCD part of the shift register is zero after the final iteration; the bench asserts this.
  - Digit correction operates only on the 4*DIGITS upper field. Binary bits are never corrected.
- Reset mid-operation: conversion aborts immediately, with reset values as above. No partial result is ever presented.
- out_valid and in_ready are never both high.

Decomposition:
- Package bcd_pkg holds:
  - DIGITS_DEF=4 and BIN_W_DEF=14;
  - state encoding IDLE=2'd0, CONV=2'd1, DONE=2'd2;
  - function digit_ok(nibble) returning nibble <= 9.
- Sub-module bcd_digit_corr: combinational, 4-bit in and 4-bit out, output = (in >= 8) ? in-3 : in. Instantiated DIGITS times via generate.
- Top module holds the FSM, counter (width $clog2(BIN_W)), shift register and output registers.

Test Plan:
- bcd_in=16'h0000, in_valid pulse, out_ready=1 -> out_valid after 15 edges, bin_out=0, err=0.
- bcd_in=16'h9999 -> bin_out=14'd9999 (0x270F), err=0; bcd_in=16'h1234 -> bin_out=14'd1234 (0x04D2).
- bcd_in=16'h12A4 -> out_valid after 1 edge, err=1, bin_out=0; digit 3 = F (16'hF000) also gives err=1.
- Backpressure: bcd_in=16'h0042, out_ready=0 for 10 cycles -> out_valid stays 1, bin_out=42 stable, in_ready=0; raising out_ready returns to IDLE next edge.
- Busy input: second in_valid with 16'h0001 asserted during CONV -> ignored; first result (e.g. 16'h0500 -> 500) unaffected; the second value is accepted only once back in IDLE.
- Reset: assert rst_n=0 at iteration 7 of 16'h8765 -> out_valid=0, in_ready=1 after release; next conversion of 16'h0007 yields 7.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the packed-BCD to binary converter.
// Default sizing, FSM state encoding and the digit legality check.
package bcd_pkg;

  localparam int DIGITS_DEF = 4;
  localparam int BIN_W_DEF  = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic digit_ok(input logic [3:0] nibble);
    return nibble <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_digit_corr.sv
// One BCD digit correction step for reverse double dabble.
// A digit that reached 8 or more after the right shift gets 3 subtracted.
module bcd_digit_corr (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd8) ? (din - 4'd3) : din;

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential packed-BCD to binary converter (reverse double dabble).
// One shift/correct iteration per clock, valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for input, in_ready high
// CONV  | one shift-right/correct iteration per edge, BIN_W iterations
// DONE  | result presented with out_valid, held until out_ready
module bcd2bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int BIN_W  = BIN_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  state_t            state_q, state_d;
  logic [SR_W-1:0]   sr_q;
  logic [SR_W-1:0]   shifted;
  logic [SR_W-1:0]   sr_next;
  logic [BCD_W-1:0]  corr;
  logic [CNT_W-1:0]  cnt_q;
  logic              all_ok;
  logic              accept;

  always_comb begin
    all_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!digit_ok(bcd_in[4*i +: 4])) all_ok = 1'b0;
    end
  end

  // Correction touches only the BCD field; the binary bits pass straight through.
  assign shifted = sr_q >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_corr
    bcd_digit_corr u_corr (
      .din  (shifted[BIN_W + 4*g +: 4]),
      .dout (corr[4*g +: 4])
    );
  end

  assign sr_next = {corr, shifted[BIN_W-1:0]};
  assign accept  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = all_ok ? CONV : DONE;
      end
      CONV: begin
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      bin_out <= '0;
      err     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (all_ok) begin
              sr_q  <= {bcd_in, {BIN_W{1'b0}}};
              cnt_q <= '0;
            end else begin
              err     <= 1'b1;
              bin_out <= '0;
            end
          end
        end
        CONV: begin
          sr_q  <= sr_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            bin_out <= sr_next[BIN_W-1:0];
            err     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed bench for bcd2bin_seq with a queue scoreboard and a
// handshake-driven monitor that pops expectations as results appear.
module tb_bcd2bin_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] bcd_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [13:0] bin_out;
  logic        err;

  typedef struct packed {
    logic [13:0] bin;
    logic        err;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;

  bcd2bin_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_in    (bcd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin_out   (bin_out),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      chk("ready_excl", int'(in_ready), 0);
      if (out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          e = q.pop_front();
          chk("bin_out", int'(bin_out), int'(e.bin));
          chk("err", int'(err), int'(e.err));
          if (!err) chk("bcd_resid", int'(dut.sr_q[29:14]), 0);
        end
      end
    end
  end

  // Issue one value; returns just after the accept edge.
  task automatic send(input logic [15:0] v, input logic [13:0] eb, input logic ee,
                      input bit push);
    int n;
    @(posedge clk); #1;
    bcd_in   = v;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("accept_timeout", 1, 0);
    if (push) q.push_back('{bin: eb, err: ee});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Edges from accept (inclusive) until out_valid is seen.
  task automatic wait_out(input string name, input int exp_lat);
    int lat;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk(name, lat, exp_lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_bin_out", int'(bin_out), 0);
    chk("rst_err", int'(err), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", int'(in_ready), 1);

    send(16'h0000, 14'd0, 1'b0, 1'b1);    wait_out("lat_0000", 15);
    send(16'h9999, 14'd9999, 1'b0, 1'b1); wait_out("lat_9999", 15);
    send(16'h12A4, 14'd0, 1'b1, 1'b1);    wait_out("lat_12A4", 1);
    send(16'h1234, 14'd1234, 1'b0, 1'b1); wait_out("lat_1234", 15);
    send(16'hF000, 14'd0, 1'b1, 1'b1);    wait_out("lat_F000", 1);

    // Backpressure: result must hold while out_ready is low.
    @(posedge clk); #1 out_ready = 1'b0;
    send(16'h0042, 14'd42, 1'b0, 1'b1);
    wait_out("lat_0042", 15);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_bin", int'(bin_out), 42);
      chk("bp_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", int'(out_valid), 0);
    chk("bp_release_ready", int'(in_ready), 1);

    // Busy input: second value held during CONV must wait for IDLE.
    send(16'h0500, 14'd500, 1'b0, 1'b1);
    bcd_in   = 16'h0001;
    in_valid = 1'b1;
    wait_out("lat_0500", 15);
    q.push_back('{bin: 14'd1, err: 1'b0});
    @(posedge clk); #1;
    chk("busy_idle_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out("lat_0001", 15);

    // Reset in the middle of a conversion.
    send(16'h8765, 14'd0, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_ready", int'(in_ready), 1);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      chk("post_rst_valid", int'(out_valid), 0);
    end
    chk("post_rst_bin", int'(bin_out), 0);
    chk("post_rst_err", int'(err), 0);
    send(16'h0007, 14'd7, 1'b0, 1'b1);    wait_out("lat_0007", 15);

    repeat (4) @(posedge clk);
    #1 chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
